rx_lock_sequencer: RTL
======================

// Module: rx_lock_sequencer
// PURPOSE
//  Supervises Rx carrier/timing acquisition: watches Costas and Gardner loop errors once per
//  recovered symbol and schedules loop gains (wide acquire -> narrow track). Declares lock,
//  gates frame reception and forces loop re-acquisition on timeout or loss of lock.
//  Sits beside the Rx chain; drives its FEEDBACK_SHIFT/GARDNER_SHIFT, consumes the Gardner strobe.
// PARAMETERS
//  ERR_W          16    width of signed loop-error inputs
//  ACQ_FB_SHIFT   4'd3  Costas feedback shift in IDLE/ACQ (wide loop)
//  TRK_FB_SHIFT   4'd7  Costas feedback shift in TRACK/LOCKED/RECEIVE
//  ACQ_GD_SHIFT   4'd2  Gardner shift in IDLE/ACQ
//  TRK_GD_SHIFT   4'd5  Gardner shift in TRACK/LOCKED/RECEIVE
//  LOCK_SYMS      256   consecutive good symbols needed per qualification stage
//  LOSS_SYMS      64    consecutive bad symbols declaring loss of lock
//  TIMEOUT_SYMS   8192  symbols allowed in ACQ+TRACK before forced resync
// PORTS
//  clk_32M768      in   1      system clock
//  rst_n_32M768    in   1      asynchronous reset, active-low
//  sym_ce          in   1      Gardner recovered strobe, 1-cycle pulse per symbol
//  enable          in   1      sequencer run; low forces IDLE
//  costas_err      in   ERR_W  signed Costas phase error
//  gardner_err     in   ERR_W  signed Gardner timing error
//  lock_thresh     in   ERR_W  unsigned |error| threshold
//  SD_flag         in   1      start-of-frame detected
//  data_tvalid     in   1      depacketizer byte valid
//  data_tlast      in   1      depacketizer last byte of frame
//  feedback_shift  out  4      to Costas FEEDBACK_SHIFT
//  gardner_shift   out  4      to Gardner GARDNER_SHIFT
//  loop_rst        out  1      1-cycle pulse: reset Costas/Gardner integrators
//  rx_state        out  3      current state encoding
//  locked          out  1      high in LOCKED and RECEIVE
//  rx_gate         out  1      high in RECEIVE only (frame accept window)
//  timeout_pulse   out  1      1-cycle pulse on acquisition timeout
//  relock_count    out  8      number of RESYNC entries, saturates at 255
// BEHAVIOUR
//  - Reset: state IDLE, shifts = ACQ_*, loop_rst/locked/rx_gate/timeout_pulse = 0, counters = 0.
//  - Symbol qualification (sym_ce only): good = |costas_err| < lock_thresh AND
//    |gardner_err| < lock_thresh; |x| saturates (-2^(ERR_W-1) -> 2^(ERR_W-1)-1); strict compare.
//    good_cnt: +1 on good, cleared on bad; bad_cnt: +1 on bad, cleared on good; both saturate.
//  - States: IDLE=0 ACQ=1 TRACK=2 LOCKED=3 RECEIVE=4 RESYNC=5.
//    IDLE: enable -> ACQ, loop_rst pulses, counters cleared.
//    ACQ: good_cnt reaches LOCK_SYMS -> TRACK (good_cnt cleared); sym_cnt reaches TIMEOUT_SYMS -> RESYNC.
//    TRACK: good_cnt reaches LOCK_SYMS -> LOCKED; bad_cnt reaches LOSS_SYMS or timeout -> RESYNC.
//    LOCKED: SD_flag -> RECEIVE; bad_cnt reaches LOSS_SYMS -> RESYNC.
//    RECEIVE: data_tvalid & data_tlast -> LOCKED; bad_cnt reaches LOSS_SYMS -> RESYNC (frame abort).
//    RESYNC: one cycle; loop_rst pulses, relock_count++ (sat), counters cleared -> ACQ.
//  - sym_cnt counts sym_ce in ACQ+TRACK, cleared on entry to ACQ; timeout_pulse fires with the
//    ACQ/TRACK -> RESYNC transition caused by timeout only.
//  - Priority: enable low > loss/timeout > lock/SD/tlast. Loss and tlast same cycle -> RESYNC.
//    Lock reached and timeout same symbol -> lock wins (TRACK/LOCKED).
//  - Latency: all outputs registered; state and shifts change 1 clk after the deciding sym_ce
//    or SD_flag/tlast cycle. Shifts follow state (no extra cycle).
//  - enable dropping mid-operation: IDLE next clk, ACQ shifts, no loop_rst, relock_count held.
//  - Counter width $clog2(TIMEOUT_SYMS+1); LOCK_SYMS, LOSS_SYMS <= TIMEOUT_SYMS.
// STRUCTURE
//  - Shared header rx_ctrl_pkg.vh: state encodings (RX_ST_*) and default shift constants.
//  - Sub-module rx_err_qualifier: abs-saturate, compare, good/bad run counters; FSM in top.
// TESTING (bench params LOCK_SYMS=8, LOSS_SYMS=4, TIMEOUT_SYMS=64, thresh=100)
//  1 Reset, enable=1, errors=0, sym_ce every 32 clk -> loop_rst pulse, TRACK after 8 syms,
//    LOCKED after 16, feedback_shift 3->7 at TRACK entry.
//  2 errors=500 constant -> timeout_pulse at sym 64, RESYNC 1 clk, relock_count=1, back in ACQ.
//  3 LOCKED, SD_flag pulse, 5 bytes with tlast on 5th -> rx_gate high, returns to LOCKED.
//  4 RECEIVE, costas_err=-32768 for 4 syms -> RESYNC, locked=0, relock_count+1.
//  5 gardner_err alternating 50/200 in ACQ -> never TRACK (good run resets); timeout at 64.
//  6 enable low in RECEIVE -> IDLE next clk, shifts ACQ, no loop_rst; 260 resyncs -> count=255.

Source files
------------

// File: rtl/rx_lock_sequencer_pkg.sv
// rtl/rx_lock_sequencer_pkg.sv - state encodings and default loop-gain constants for the Rx lock sequencer
package rx_lock_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQ     = 3'd1,
    ST_TRACK   = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_RECEIVE = 3'd4,
    ST_RESYNC  = 3'd5
  } rx_state_e;

  localparam int         DEF_ERR_W        = 16;
  localparam logic [3:0] DEF_ACQ_FB_SHIFT = 4'd3;
  localparam logic [3:0] DEF_TRK_FB_SHIFT = 4'd7;
  localparam logic [3:0] DEF_ACQ_GD_SHIFT = 4'd2;
  localparam logic [3:0] DEF_TRK_GD_SHIFT = 4'd5;
  localparam int         DEF_LOCK_SYMS    = 256;
  localparam int         DEF_LOSS_SYMS    = 64;
  localparam int         DEF_TIMEOUT_SYMS = 8192;

endpackage

// File: rtl/rx_lock_sequencer_if.sv
// rtl/rx_lock_sequencer_if.sv - loop-error inputs, frame handshake and loop-control outputs of the lock sequencer
interface rx_lock_sequencer_if #(
  parameter int ERR_W = 16
);

  logic                    sym_ce;
  logic                    enable;
  logic signed [ERR_W-1:0] costas_err;
  logic signed [ERR_W-1:0] gardner_err;
  logic        [ERR_W-1:0] lock_thresh;
  logic                    SD_flag;
  logic                    data_tvalid;
  logic                    data_tlast;
  logic        [3:0]       feedback_shift;
  logic        [3:0]       gardner_shift;
  logic                    loop_rst;
  logic        [2:0]       rx_state;
  logic                    locked;
  logic                    rx_gate;
  logic                    timeout_pulse;
  logic        [7:0]       relock_count;

  modport slave (
    input  sym_ce, enable, costas_err, gardner_err, lock_thresh,
           SD_flag, data_tvalid, data_tlast,
    output feedback_shift, gardner_shift, loop_rst, rx_state,
           locked, rx_gate, timeout_pulse, relock_count
  );

  modport master (
    output sym_ce, enable, costas_err, gardner_err, lock_thresh,
           SD_flag, data_tvalid, data_tlast,
    input  feedback_shift, gardner_shift, loop_rst, rx_state,
           locked, rx_gate, timeout_pulse, relock_count
  );

endinterface

// File: rtl/rx_lock_sequencer_qual.sv
// rtl/rx_lock_sequencer_qual.sv - per-symbol error qualification with good/bad run counters
module rx_lock_sequencer_qual #(
  parameter int ERR_W     = 16,
  parameter int CNT_W     = 14,
  parameter int LOCK_SYMS = 256,
  parameter int LOSS_SYMS = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_sym_ce,
  input  logic                    i_clear,
  input  logic signed [ERR_W-1:0] i_costas_err,
  input  logic signed [ERR_W-1:0] i_gardner_err,
  input  logic        [ERR_W-1:0] i_lock_thresh,
  output logic                    o_lock_hit,
  output logic                    o_loss_hit
);

  localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_SYMS);
  localparam logic [CNT_W-1:0] LOSS_C  = CNT_W'(LOSS_SYMS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] r_bad_cnt;
  logic [ERR_W-1:0] w_abs_costas;
  logic [ERR_W-1:0] w_abs_gardner;
  logic             w_good;
  logic [CNT_W-1:0] w_good_inc;
  logic [CNT_W-1:0] w_bad_inc;

  // The most negative code has no positive twin, so it clamps to the largest positive value.
  function automatic logic [ERR_W-1:0] abs_sat(input logic signed [ERR_W-1:0] x);
    logic [ERR_W-1:0] r;
    if (x == {1'b1, {(ERR_W-1){1'b0}}})
      r = {1'b0, {(ERR_W-1){1'b1}}};
    else if (x[ERR_W-1])
      r = $unsigned(-x);
    else
      r = $unsigned(x);
    return r;
  endfunction

  assign w_abs_costas  = abs_sat(i_costas_err);
  assign w_abs_gardner = abs_sat(i_gardner_err);
  assign w_good        = (w_abs_costas < i_lock_thresh) && (w_abs_gardner < i_lock_thresh);
  assign w_good_inc    = (r_good_cnt == CNT_MAX) ? r_good_cnt : r_good_cnt + 1'b1;
  assign w_bad_inc     = (r_bad_cnt == CNT_MAX) ? r_bad_cnt : r_bad_cnt + 1'b1;
  assign o_lock_hit    = i_sym_ce && w_good && (w_good_inc >= LOCK_C);
  assign o_loss_hit    = i_sym_ce && !w_good && (w_bad_inc >= LOSS_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else if (i_clear) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else if (i_sym_ce) begin
      if (w_good) begin
        r_good_cnt <= w_good_inc;
        r_bad_cnt  <= '0;
      end else begin
        r_good_cnt <= '0;
        r_bad_cnt  <= w_bad_inc;
      end
    end
  end

endmodule

// File: rtl/rx_lock_sequencer.sv
// rtl/rx_lock_sequencer.sv - acquisition/track/lock FSM scheduling Costas and Gardner loop gains
module rx_lock_sequencer
  import rx_lock_sequencer_pkg::*;
#(
  parameter int         ERR_W        = DEF_ERR_W,
  parameter logic [3:0] ACQ_FB_SHIFT = DEF_ACQ_FB_SHIFT,
  parameter logic [3:0] TRK_FB_SHIFT = DEF_TRK_FB_SHIFT,
  parameter logic [3:0] ACQ_GD_SHIFT = DEF_ACQ_GD_SHIFT,
  parameter logic [3:0] TRK_GD_SHIFT = DEF_TRK_GD_SHIFT,
  parameter int         LOCK_SYMS    = DEF_LOCK_SYMS,
  parameter int         LOSS_SYMS    = DEF_LOSS_SYMS,
  parameter int         TIMEOUT_SYMS = DEF_TIMEOUT_SYMS
) (
  input logic                clk_32M768,
  input logic                rst_n_32M768,
  rx_lock_sequencer_if.slave bus
);

  localparam int               CNT_W     = $clog2(TIMEOUT_SYMS + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_SYMS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  rx_state_e        r_state;
  rx_state_e        w_next;
  logic [CNT_W-1:0] r_sym_cnt;
  logic [CNT_W-1:0] w_sym_inc;
  logic [3:0]       r_fb_shift;
  logic [3:0]       r_gd_shift;
  logic             r_loop_rst;
  logic             r_locked;
  logic             r_rx_gate;
  logic             r_timeout;
  logic [7:0]       r_relock_cnt;
  logic             w_q_clear;
  logic             w_sym_clear;
  logic             w_timeout_sel;
  logic             w_lock_hit;
  logic             w_loss_hit;
  logic             w_timeout_hit;
  logic             w_narrow;

  rx_lock_sequencer_qual #(
    .ERR_W     (ERR_W),
    .CNT_W     (CNT_W),
    .LOCK_SYMS (LOCK_SYMS),
    .LOSS_SYMS (LOSS_SYMS)
  ) u_qual (
    .clk           (clk_32M768),
    .rst_n         (rst_n_32M768),
    .i_sym_ce      (bus.sym_ce),
    .i_clear       (w_q_clear),
    .i_costas_err  (bus.costas_err),
    .i_gardner_err (bus.gardner_err),
    .i_lock_thresh (bus.lock_thresh),
    .o_lock_hit    (w_lock_hit),
    .o_loss_hit    (w_loss_hit)
  );

  assign w_sym_inc     = (r_sym_cnt == CNT_MAX) ? r_sym_cnt : r_sym_cnt + 1'b1;
  assign w_timeout_hit = bus.sym_ce && (r_state == ST_ACQ || r_state == ST_TRACK) &&
                         (w_sym_inc >= TIMEOUT_C);

  // Lock is tested before timeout so a run completing on the last allowed symbol still locks.
  always_comb begin
    w_next        = r_state;
    w_q_clear     = 1'b0;
    w_timeout_sel = 1'b0;
    if (!bus.enable) begin
      w_next    = ST_IDLE;
      w_q_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next    = ST_ACQ;
          w_q_clear = 1'b1;
        end
        ST_ACQ: begin
          if (w_lock_hit) begin
            w_next    = ST_TRACK;
            w_q_clear = 1'b1;
          end else if (w_timeout_hit) begin
            w_next        = ST_RESYNC;
            w_timeout_sel = 1'b1;
          end
        end
        ST_TRACK: begin
          if (w_loss_hit) begin
            w_next = ST_RESYNC;
          end else if (w_lock_hit) begin
            w_next = ST_LOCKED;
          end else if (w_timeout_hit) begin
            w_next        = ST_RESYNC;
            w_timeout_sel = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_loss_hit)       w_next = ST_RESYNC;
          else if (bus.SD_flag) w_next = ST_RECEIVE;
        end
        ST_RECEIVE: begin
          if (w_loss_hit)                              w_next = ST_RESYNC;
          else if (bus.data_tvalid && bus.data_tlast)  w_next = ST_LOCKED;
        end
        ST_RESYNC: begin
          w_next    = ST_ACQ;
          w_q_clear = 1'b1;
        end
        default: begin
          w_next    = ST_IDLE;
          w_q_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_sym_clear = (w_next == ST_IDLE) || (w_next == ST_ACQ && r_state != ST_ACQ);
  assign w_narrow    = (w_next == ST_TRACK) || (w_next == ST_LOCKED) || (w_next == ST_RECEIVE);

  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      r_state      <= ST_IDLE;
      r_sym_cnt    <= '0;
      r_fb_shift   <= ACQ_FB_SHIFT;
      r_gd_shift   <= ACQ_GD_SHIFT;
      r_loop_rst   <= 1'b0;
      r_locked     <= 1'b0;
      r_rx_gate    <= 1'b0;
      r_timeout    <= 1'b0;
      r_relock_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_fb_shift <= w_narrow ? TRK_FB_SHIFT : ACQ_FB_SHIFT;
      r_gd_shift <= w_narrow ? TRK_GD_SHIFT : ACQ_GD_SHIFT;
      r_loop_rst <= (w_next == ST_RESYNC) || (r_state == ST_IDLE && w_next == ST_ACQ);
      r_locked   <= (w_next == ST_LOCKED) || (w_next == ST_RECEIVE);
      r_rx_gate  <= (w_next == ST_RECEIVE);
      r_timeout  <= w_timeout_sel;
      if (w_sym_clear)
        r_sym_cnt <= '0;
      else if (bus.sym_ce && (r_state == ST_ACQ || r_state == ST_TRACK))
        r_sym_cnt <= w_sym_inc;
      if (w_next == ST_RESYNC && r_relock_cnt != 8'hFF)
        r_relock_cnt <= r_relock_cnt + 8'd1;
    end
  end

  assign bus.rx_state       = r_state;
  assign bus.feedback_shift = r_fb_shift;
  assign bus.gardner_shift  = r_gd_shift;
  assign bus.loop_rst       = r_loop_rst;
  assign bus.locked         = r_locked;
  assign bus.rx_gate        = r_rx_gate;
  assign bus.timeout_pulse  = r_timeout;
  assign bus.relock_count   = r_relock_cnt;

endmodule
